// File: rtl/raster_scan_reader.sv
`default_nettype none
// ============================================================================
//  Module      : raster_scan_reader
//  Description : Laser raster scanner front end. It walks a framebuffer in
//                raster order, one read per pixel strobe, and registers each
//                returned intensity onto the laser output. Frame and line
//                syncs come from the mirror and polygon facets; aborts,
//                overruns and enable drops discard any reads still in flight.
//                Optional build macro RASTER_MIRROR_X_EN makes odd lines
//                scan in descending column order (bidirectional facets).
//  Revision    : 1.0 - initial release
// ============================================================================
module raster_scan_reader #(
    parameter int H_PIXELS     = 640,
    parameter int V_LINES      = 480,
    parameter int READ_LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        frame_sync,
    input  logic        line_sync,
    input  logic        pixel_tick,
    output logic [18:0] fb_address,
    output logic        fb_chipselect,
    output logic        fb_clken,
    output logic        fb_write,
    input  logic [7:0]  fb_readdata,
    output logic [7:0]  laser_data,
    output logic        laser_valid,
    output logic        line_active,
    output logic        line_overrun,
    output logic        frame_done
);

    // Column counter must be able to hold H_PIXELS (one past the last pixel).
    localparam int COL_W  = $clog2(H_PIXELS + 1);
    localparam int LINE_W = (V_LINES > 1) ? $clog2(V_LINES) : 1;
    localparam int DRN_W  = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

    localparam logic [1:0] c_idle      = 2'd0;
    localparam logic [1:0] c_wait_line = 2'd1;
    localparam logic [1:0] c_scan      = 2'd2;
    localparam logic [1:0] c_drain     = 2'd3;

    localparam logic [COL_W-1:0]  c_col_last   = COL_W'(H_PIXELS - 1);
    localparam logic [LINE_W-1:0] c_line_last  = LINE_W'(V_LINES - 1);
    localparam logic [DRN_W-1:0]  c_drain_last = DRN_W'(READ_LATENCY - 1);
    localparam logic [18:0]       c_line_step  = 19'(H_PIXELS);
    localparam logic [18:0]       c_col_span   = 19'(H_PIXELS - 1);

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [LINE_W-1:0]       r_line;
    logic [COL_W-1:0]        r_col;
    logic [18:0]             r_line_base;
    logic [DRN_W-1:0]        r_drain_cnt;
    logic [READ_LATENCY-1:0] r_pend;
    logic [7:0]              r_laser_data;
    logic                    r_laser_valid;
    logic                    r_overrun;
    logic                    r_frame_done;

    logic        w_scan_or_drain;
    logic        w_last_line;
    logic        w_frame_restart;
    logic        w_line_start;
    logic        w_line_overrun_evt;
    logic        w_issue;
    logic        w_last_tick;
    logic        w_drain_end;
    logic        w_flush;
    logic [18:0] w_col_offset;
    logic [18:0] w_read_addr;

    // ------------------------------------------------------------------
    // Event decode. frame_sync takes priority over line_sync, so a
    // coincident pair behaves as "restart frame, then start line 0".
    // ------------------------------------------------------------------
    assign w_scan_or_drain    = (r_state == c_scan) || (r_state == c_drain);
    assign w_last_line        = (r_line == c_line_last);
    assign w_frame_restart    = enable && frame_sync;
    assign w_line_start       = enable && line_sync && !frame_sync && (r_state == c_wait_line);
    assign w_line_overrun_evt = enable && line_sync && !frame_sync && w_scan_or_drain;
    assign w_issue            = enable && pixel_tick && !frame_sync && !line_sync
                                && (r_state == c_scan);
    assign w_last_tick        = w_issue && (r_col == c_col_last);
    assign w_drain_end        = enable && !frame_sync && !line_sync
                                && (r_state == c_drain) && (r_drain_cnt == c_drain_last);
    // Any of these throws away reads that have not yet returned.
    assign w_flush            = !enable || w_frame_restart || w_line_overrun_evt;

    // Column offset within the line; odd lines may run right-to-left.
`ifdef RASTER_MIRROR_X_EN
    assign w_col_offset = r_line[0] ? (c_col_span - 19'(r_col)) : 19'(r_col);
`else
    assign w_col_offset = 19'(r_col);
`endif
    assign w_read_addr  = r_line_base + w_col_offset;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        if (!enable) begin
            w_state_nxt = c_idle;
        end else if (frame_sync) begin
            w_state_nxt = line_sync ? c_scan : c_wait_line;
        end else begin
            case (r_state)
                c_idle: begin
                    w_state_nxt = c_idle;
                end
                c_wait_line: begin
                    if (line_sync) begin
                        w_state_nxt = c_scan;
                    end
                end
                c_scan: begin
                    if (line_sync) begin
                        w_state_nxt = c_scan;
                    end else if (w_last_tick) begin
                        w_state_nxt = c_drain;
                    end
                end
                c_drain: begin
                    if (line_sync) begin
                        w_state_nxt = c_scan;
                    end else if (w_drain_end) begin
                        w_state_nxt = w_last_line ? c_idle : c_wait_line;
                    end
                end
                default: begin
                    w_state_nxt = c_idle;
                end
            endcase
        end
    end

    // FSM-derived outputs; the read request is presented in the tick cycle.
    always_comb begin
        line_active   = w_scan_or_drain;
        fb_chipselect = w_issue;
        fb_clken      = w_issue || (|r_pend);
        fb_address    = w_issue ? w_read_addr : 19'd0;
    end

    assign fb_write = 1'b0;

    // Line/column/drain counters, line-base accumulator, sticky overrun flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_line       <= '0;
            r_col        <= '0;
            r_line_base  <= '0;
            r_drain_cnt  <= '0;
            r_overrun    <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_frame_restart) begin
                r_line      <= '0;
                r_line_base <= '0;
                r_col       <= '0;
            end else if (w_line_overrun_evt) begin
                r_overrun <= 1'b1;
                r_col     <= '0;
                // An overrun on the final line wraps back to line 0.
                if (w_last_line) begin
                    r_line      <= '0;
                    r_line_base <= '0;
                end else begin
                    r_line      <= r_line + LINE_W'(1);
                    r_line_base <= r_line_base + c_line_step;
                end
            end else if (w_line_start) begin
                r_col <= '0;
            end else if (w_issue) begin
                r_col <= r_col + COL_W'(1);
                if (w_last_tick) begin
                    r_drain_cnt <= '0;
                end
            end else if (enable && (r_state == c_drain)) begin
                if (w_drain_end) begin
                    if (w_last_line) begin
                        r_line       <= '0;
                        r_line_base  <= '0;
                        r_frame_done <= 1'b1;
                    end else begin
                        r_line      <= r_line + LINE_W'(1);
                        r_line_base <= r_line_base + c_line_step;
                    end
                end else begin
                    r_drain_cnt <= r_drain_cnt + DRN_W'(1);
                end
            end
        end
    end

    // Read-in-flight tracking and laser capture: the oldest pending read
    // lines up with fb_readdata, which is then registered onto the laser.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pend        <= '0;
            r_laser_data  <= 8'd0;
            r_laser_valid <= 1'b0;
        end else if (w_flush) begin
            r_pend        <= '0;
            r_laser_data  <= 8'd0;
            r_laser_valid <= 1'b0;
        end else begin
            r_pend[0] <= w_issue;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pend[i] <= r_pend[i-1];
            end
            if (r_pend[READ_LATENCY-1]) begin
                r_laser_data  <= fb_readdata;
                r_laser_valid <= 1'b1;
            end else if (!w_scan_or_drain && (r_pend == '0)) begin
                // Line finished and nothing left to return: blank the laser.
                r_laser_data  <= 8'd0;
                r_laser_valid <= 1'b0;
            end
        end
    end

    assign laser_data   = r_laser_data;
    assign laser_valid  = r_laser_valid;
    assign line_overrun = r_overrun;
    assign frame_done   = r_frame_done;

endmodule
`default_nettype wire
